seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: snapshots digit nibbles, then cycles a one-hot anode across them.
// Latency: one clk from snapshot/index to seg/dp/an; a load is visible on seg one edge after it is captured.
// Backpressure: none, load may be held every cycle; blank_lz feeds the output register with no snapshot.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
  // Inversion is folded into the output flops, so their reset value is the inactive level.
  localparam logic INV = (ACTIVE_LOW != 0);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic                    wrap;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [NUM_DIGITS-1:0]   cur_an;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    zero_acc;
  logic                    blank_cur;
  logic [6:0]              seg_raw;
  logic                    dp_raw;
  logic [NUM_DIGITS-1:0]   an_raw;

  // Segment pattern {a..g}; 10..15 only light up in hex mode.
  function automatic logic [6:0] decode7(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'd0:    r = 7'b1111110;
      4'd1:    r = 7'b0110000;
      4'd2:    r = 7'b1101101;
      4'd3:    r = 7'b1111001;
      4'd4:    r = 7'b0110011;
      4'd5:    r = 7'b1011011;
      4'd6:    r = 7'b1011111;
      4'd7:    r = 7'b1110000;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1111011;
      4'd10:   r = (HEX_MODE != 0) ? 7'b1110111 : 7'b0000000;
      4'd11:   r = (HEX_MODE != 0) ? 7'b0011111 : 7'b0000000;
      4'd12:   r = (HEX_MODE != 0) ? 7'b1001110 : 7'b0000000;
      4'd13:   r = (HEX_MODE != 0) ? 7'b0111101 : 7'b0000000;
      4'd14:   r = (HEX_MODE != 0) ? 7'b1001111 : 7'b0000000;
      default: r = (HEX_MODE != 0) ? 7'b1000111 : 7'b0000000;
    endcase
    return r;
  endfunction

  // Prescaler and digit index; a tick is the last count of a slot and moves the index on.
  always_comb begin
    tick         = (cnt_q == CNT_MAX);
    wrap         = tick && (idx_q == IDX_MAX);
    cnt_d        = tick ? '0 : cnt_q + CW'(1);
    idx_d        = idx_q;
    if (tick) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    frame_done_d = wrap;
  end

  // Snapshot follows the inputs on any load edge, independent of scan position.
  always_comb begin
    snap_d = load ? digits : snap_q;
    dps_d  = load ? dp_in  : dps_q;
  end

  // Select the active digit and work out whether it lies inside the leading-zero run.
  always_comb begin
    cur_nib   = 4'd0;
    cur_dp    = 1'b0;
    cur_an    = '0;
    zero_from = '0;
    zero_acc  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = snap_q[4*i +: 4];
        cur_dp    = dps_q[i];
        cur_an[i] = 1'b1;
      end
    end
    // zero_from[i] is set when every digit from the top down to i is zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc && (snap_q[4*i +: 4] == 4'd0);
      zero_from[i] = zero_acc;
    end
    // Digit 0 always shows, so a value of zero still reads "0".
    blank_cur = blank_lz && (idx_q != '0) && (|(zero_from & cur_an));
  end

  // Output value: decode, blanking, then a one-cycle dark gap on the tick, then polarity.
  always_comb begin
    seg_raw = blank_cur ? 7'b0000000 : decode7(cur_nib);
    dp_raw  = cur_dp;
    an_raw  = cur_an;
    if (tick) begin
      seg_raw = 7'b0000000;
      dp_raw  = 1'b0;
      an_raw  = '0;
    end
    seg_d = seg_raw ^ {7{INV}};
    dp_d  = dp_raw ^ INV;
    an_d  = an_raw ^ {NUM_DIGITS{INV}};
  end

  // Scan position state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Digit/decimal-point snapshot; cleared by reset so nothing loaded before it survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      dps_q  <= '0;
    end else begin
      snap_q <= snap_d;
      dps_q  <= dps_d;
    end
  end

  // Output register; reset drives the inactive level for the selected polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= {7{INV}};
      dp_q         <= INV;
      an_q         <= {NUM_DIGITS{INV}};
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: four instances (BCD, hex, active-low, single digit) share one stimulus.
// Latency: expected outputs are predicted one edge ahead and sampled 1 time unit after each rising edge.
// Backpressure: none; stimulus is applied every cycle.
module tb_seg7_scan_driver;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;

  logic [6:0] seg_m, seg_h, seg_a, seg_o;
  logic       dp_m, dp_h, dp_a, dp_o;
  logic [3:0] an_m, an_h, an_a;
  logic       an_o;
  logic       fd_m, fd_h, fd_a, fd_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: edges since reset release and the captured snapshot.
  int          k = 0;
  logic [15:0] m_snap = 16'h0;
  logic [3:0]  m_dps = 4'h0;
  logic [12:0] exp_m, exp_h, exp_a, exp_o;

  // Samples from run_frame, indexed by edge number after release.
  logic [6:0] s_seg_m [64];
  logic [6:0] s_seg_h [64];
  logic [3:0] s_an_m  [64];
  logic       s_dp_m  [64];
  logic       s_fd_m  [64];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(S), .HEX_MODE(0), .ACTIVE_LOW(0)) u_main (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .seg(seg_m), .dp(dp_m), .an(an_m), .frame_done(fd_m));
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(S), .HEX_MODE(1), .ACTIVE_LOW(0)) u_hex (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .seg(seg_h), .dp(dp_h), .an(an_h), .frame_done(fd_h));
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(S), .HEX_MODE(0), .ACTIVE_LOW(1)) u_al (
    .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .load(load), .blank_lz(blank_lz),
    .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));
  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(S), .HEX_MODE(0), .ACTIVE_LOW(0)) u_one (
    .clk(clk), .rst_n(rst_n), .digits(digits[3:0]), .dp_in(dp_in[0]), .load(load), .blank_lz(blank_lz),
    .seg(seg_o), .dp(dp_o), .an(an_o), .frame_done(fd_o));

  function automatic logic [6:0] ref_dec(input logic [3:0] v, input bit hex);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
          7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (v > 4'd9 && !hex) return 7'b0000000;
    return t[v];
  endfunction

  // Display rule for edge kk after release: slot = kk/S, the first edge of each slot is dark.
  // Packed as {seg[6:0], dp, an[3:0], frame_done}.
  function automatic logic [12:0] model_out(input int nd, input bit hex, input bit al, input int kk,
                                            input logic [15:0] sn, input logic [3:0] dps,
                                            input bit blank, input bit in_rst);
    int idx;
    logic [6:0] s;
    logic d;
    logic [3:0] a;
    logic f;
    logic [3:0] nib;
    s = 7'b0; d = 1'b0; a = 4'b0; f = 1'b0;
    if (!in_rst) begin
      idx = (kk / S) % nd;
      f = ((kk % (S * nd)) == 0);
      if ((kk % S) != 0) begin
        nib = sn[4*idx +: 4];
        s = ref_dec(nib, hex);
        if (blank && idx != 0 && (sn >> (4 * idx)) == 16'd0) s = 7'b0;
        d = dps[idx];
        a = 4'b0001 << idx;
      end
    end
    if (al) begin
      s = ~s; d = ~d; a = ~a;
    end
    return {s, d, a, f};
  endfunction

  // Predict the next edge from current inputs, then advance one clock and settle.
  task automatic step();
    if (!rst_n) begin
      k = 0; m_snap = 16'h0; m_dps = 4'h0;
    end else begin
      k++;
    end
    exp_m = model_out(4, 1'b0, 1'b0, k, m_snap, m_dps, blank_lz, !rst_n);
    exp_h = model_out(4, 1'b1, 1'b0, k, m_snap, m_dps, blank_lz, !rst_n);
    exp_a = model_out(4, 1'b0, 1'b1, k, m_snap, m_dps, blank_lz, !rst_n);
    exp_o = model_out(1, 1'b0, 1'b0, k, m_snap, m_dps, blank_lz, !rst_n);
    if (rst_n && load) begin
      m_snap = digits; m_dps = dp_in;
    end
    @(posedge clk);
    #1;
  endtask

  // Reset with a load pending, release, and record n edges of output (blank_lz switches at edge 17).
  task automatic run_frame(input logic [15:0] dig, input logic [3:0] dpv, input bit b1, input bit b2,
                           input int n);
    rst_n = 1'b0; digits = dig; dp_in = dpv; load = 1'b1; blank_lz = b1;
    step();
    step();
    rst_n = 1'b1;
    for (int kk = 1; kk <= n; kk++) begin
      if (kk == 17) blank_lz = b2;
      step();
      s_seg_m[kk] = seg_m; s_seg_h[kk] = seg_h; s_an_m[kk] = an_m;
      s_dp_m[kk] = dp_m;   s_fd_m[kk] = fd_m;
      if (kk == 1) load = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; digits = 16'h1234; dp_in = 4'hF; blank_lz = 1'b0;
    step();
    step();
    n_checks++;
    if ({seg_m, dp_m, an_m, fd_m} !== 13'b0)
      begin n_fail++; $display("FAIL reset_main got=%b want=%b", {seg_m, dp_m, an_m, fd_m}, 13'b0); end
    n_checks++;
    if ({seg_a, dp_a, an_a, fd_a} !== {7'b1111111, 1'b1, 4'b1111, 1'b0})
      begin n_fail++; $display("FAIL reset_active_low got=%b want=%b", {seg_a, dp_a, an_a, fd_a}, {7'b1111111, 1'b1, 4'b1111, 1'b0}); end
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({an_m, seg_m} !== {4'b0001, 7'b1111110})
      begin n_fail++; $display("FAIL release_main got=%b want=%b", {an_m, seg_m}, {4'b0001, 7'b1111110}); end
    n_checks++;
    if ({an_a, seg_a, dp_a} !== {4'b1110, 7'b0000001, 1'b1})
      begin n_fail++; $display("FAIL release_active_low got=%b want=%b", {an_a, seg_a, dp_a}, {4'b1110, 7'b0000001, 1'b1}); end
    n_checks++;
    if ({an_o, seg_o} !== {1'b1, 7'b1111110})
      begin n_fail++; $display("FAIL release_one_digit got=%b want=%b", {an_o, seg_o}, {1'b1, 7'b1111110}); end
    load = 1'b0;
  endtask

  task automatic test_sequence();
    logic [6:0] want_seg [4];
    want_seg = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    run_frame(16'h1234, 4'b0100, 1'b0, 1'b0, 16);
    for (int j = 0; j < 4; j++) begin
      for (int o = 1; o <= 3; o++) begin
        n_checks++;
        if (s_an_m[4*j+o] !== (4'b0001 << j))
          begin n_fail++; $display("FAIL seq_an slot=%0d k=%0d got=%b want=%b", j, 4*j+o, s_an_m[4*j+o], 4'b0001 << j); end
      end
      n_checks++;
      if ({s_seg_m[4*j+2], s_dp_m[4*j+2]} !== {want_seg[j], (j == 2)})
        begin n_fail++; $display("FAIL seq_seg slot=%0d got=%b want=%b", j, {s_seg_m[4*j+2], s_dp_m[4*j+2]}, {want_seg[j], (j == 2)}); end
      n_checks++;
      if ({s_an_m[4*j+4], s_seg_m[4*j+4], s_dp_m[4*j+4], s_fd_m[4*j+4]} !== {11'b0, 1'b0, (j == 3)})
        begin n_fail++; $display("FAIL seq_gap slot=%0d got=%b want=%b", j, {s_an_m[4*j+4], s_seg_m[4*j+4], s_dp_m[4*j+4], s_fd_m[4*j+4]}, {11'b0, 1'b0, (j == 3)}); end
    end
  endtask

  task automatic test_frame_done();
    int pulses;
    pulses = 0;
    rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 48; i++) begin
      step();
      if (fd_m) pulses++;
      n_checks++;
      if ({fd_m, fd_m && (an_m != 4'b0)} !== {(i % 16) == 0, 1'b0})
        begin n_fail++; $display("FAIL frame_done k=%0d got=%b an=%b want=%b", i, fd_m, an_m, (i % 16) == 0); end
      n_checks++;
      if ({fd_o, an_o} !== {(i % 4) == 0, (i % 4) != 0})
        begin n_fail++; $display("FAIL one_digit k=%0d got=%b want=%b", i, {fd_o, an_o}, {(i % 4) == 0, (i % 4) != 0}); end
    end
    n_checks++;
    if (pulses !== 3) begin n_fail++; $display("FAIL frame_count got=%0d want=3", pulses); end
  endtask

  task automatic test_blanking();
    logic [6:0] want_b [4];
    logic [6:0] want_n [4];
    want_b = '{7'b1111110, 7'b1011011, 7'b0000000, 7'b0000000};
    want_n = '{7'b1111110, 7'b1011011, 7'b1111110, 7'b1111110};
    run_frame(16'h0050, 4'b0000, 1'b1, 1'b0, 32);
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (s_seg_m[4*j+2] !== want_b[j])
        begin n_fail++; $display("FAIL blank_on digit=%0d got=%b want=%b", j, s_seg_m[4*j+2], want_b[j]); end
      n_checks++;
      if (s_seg_m[16+4*j+2] !== want_n[j])
        begin n_fail++; $display("FAIL blank_off digit=%0d got=%b want=%b", j, s_seg_m[16+4*j+2], want_n[j]); end
    end
  endtask

  task automatic test_hex();
    logic [6:0] want_h [4];
    want_h = '{7'b1000111, 7'b1001110, 7'b0011111, 7'b1110111};
    run_frame(16'hABCF, 4'b0000, 1'b0, 1'b0, 16);
    for (int j = 0; j < 4; j++) begin
      n_checks++;
      if (s_seg_m[4*j+3] !== 7'b0000000)
        begin n_fail++; $display("FAIL bcd_over9 digit=%0d got=%b want=%b", j, s_seg_m[4*j+3], 7'b0); end
      n_checks++;
      if (s_seg_h[4*j+3] !== want_h[j])
        begin n_fail++; $display("FAIL hex_decode digit=%0d got=%b want=%b", j, s_seg_h[4*j+3], want_h[j]); end
    end
  endtask

  task automatic test_reset_mid();
    run_frame(16'h1234, 4'b0100, 1'b0, 1'b0, 10);
    n_checks++;
    if (an_m !== 4'b0100) begin n_fail++; $display("FAIL mid_pre got=%b want=%b", an_m, 4'b0100); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({seg_m, dp_m, an_m, fd_m} !== 13'b0)
      begin n_fail++; $display("FAIL mid_async_main got=%b want=%b", {seg_m, dp_m, an_m, fd_m}, 13'b0); end
    n_checks++;
    if ({seg_a, dp_a, an_a} !== 12'hFFF)
      begin n_fail++; $display("FAIL mid_async_al got=%b want=%b", {seg_a, dp_a, an_a}, 12'hFFF); end
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_checks++;
      if ({an_m, seg_m, dp_m} !== {4'b0001, 7'b1111110, 1'b0})
        begin n_fail++; $display("FAIL mid_restart k=%0d got=%b want=%b", i, {an_m, seg_m, dp_m}, {4'b0001, 7'b1111110, 1'b0}); end
    end
  endtask

  task automatic test_random();
    logic [15:0] d;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      for (int n = 0; n < 4; n++)
        d[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      digits = d;
      dp_in = 4'($urandom_range(0, 15));
      load = ($urandom_range(0, 2) == 0);
      blank_lz = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      n_checks++;
      if ({seg_m, dp_m, an_m, fd_m} !== exp_m)
        begin n_fail++; $display("FAIL rand_main i=%0d got=%b want=%b", i, {seg_m, dp_m, an_m, fd_m}, exp_m); end
      n_checks++;
      if ({seg_h, dp_h, an_h, fd_h} !== exp_h)
        begin n_fail++; $display("FAIL rand_hex i=%0d got=%b want=%b", i, {seg_h, dp_h, an_h, fd_h}, exp_h); end
      n_checks++;
      if ({seg_a, dp_a, an_a, fd_a} !== exp_a)
        begin n_fail++; $display("FAIL rand_al i=%0d got=%b want=%b", i, {seg_a, dp_a, an_a, fd_a}, exp_a); end
      n_checks++;
      if ({seg_o, dp_o, an_o, fd_o} !== {exp_o[12:5], exp_o[1], exp_o[0]})
        begin n_fail++; $display("FAIL rand_one i=%0d got=%b want=%b", i, {seg_o, dp_o, an_o, fd_o}, {exp_o[12:5], exp_o[1], exp_o[0]}); end
    end
    rst_n = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_frame_done();
    test_blanking();
    test_hex();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
